// File: rtl/chroma_multi_tracker.sv
// rtl/chroma_multi_tracker.sv - multi-channel chroma classifier and extreme-point tracker
//
// Purpose: classifies each pixel against NUM_COLORS Cb/Cr windows, qualifies
// matches with a per-pixel temporal history, shifts the history for write-back
// and tracks the TL/TR/BL/BR extreme points of the winning channel. At each
// vga_vs falling edge the working extremes become the published snapshot.
//
// Ports:
//   clk, reset                  pixel clock, synchronous active-high reset
//   vga_vs                      vertical sync, falling edge = frame boundary
//   pix_valid, cb, cr           pixel strobe and chroma
//   rd_x, rd_y, rd_addr         pixel coordinates and history RAM address
//   hist_in                     stored history, NUM_COLORS x HIST_DEPTH, bit 0 newest
//   cb_lo/cb_hi/cr_lo/cr_hi     inclusive per-channel windows (8 bits each)
//   hist_thresh                 per-channel popcount threshold (4 bits each)
//   det_valid, det_color        output strobe, 1+winning channel (0 = none)
//   det_corner, det_x, det_y    snapshot corner hit (0 none,1 TL,2 TR,3 BL,4 BR), coords
//   hist_out, we, wr_addr       history write-back port
//   sel_color                   snapshot read select
//   snap_valid, snap_*_x/y      selected channel's previous-frame snapshot
//   frame_done                  pulse on the cycle after a snapshot
//   pix_count                   selected channel's match count
//
// Optional: define CHROMA_PIXEL_COUNT_EN to build per-channel saturating
// 20-bit match counters; otherwise pix_count is tied to 0.

module chroma_multi_tracker #(
  parameter int NUM_COLORS = 2,
  parameter int HIST_DEPTH = 4,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             vga_vs,
  input  logic                             pix_valid,
  input  logic [7:0]                       cb,
  input  logic [7:0]                       cr,
  input  logic [9:0]                       rd_x,
  input  logic [9:0]                       rd_y,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [NUM_COLORS*HIST_DEPTH-1:0] hist_in,
  input  logic [NUM_COLORS*8-1:0]          cb_lo,
  input  logic [NUM_COLORS*8-1:0]          cb_hi,
  input  logic [NUM_COLORS*8-1:0]          cr_lo,
  input  logic [NUM_COLORS*8-1:0]          cr_hi,
  input  logic [NUM_COLORS*4-1:0]          hist_thresh,
  output logic                             det_valid,
  output logic [2:0]                       det_color,
  output logic [2:0]                       det_corner,
  output logic [9:0]                       det_x,
  output logic [9:0]                       det_y,
  output logic [NUM_COLORS*HIST_DEPTH-1:0] hist_out,
  output logic                             we,
  output logic [ADDR_W-1:0]                wr_addr,
  input  logic [2:0]                       sel_color,
  output logic                             snap_valid,
  output logic [9:0]                       snap_tl_x,
  output logic [9:0]                       snap_tl_y,
  output logic [9:0]                       snap_tr_x,
  output logic [9:0]                       snap_tr_y,
  output logic [9:0]                       snap_bl_x,
  output logic [9:0]                       snap_bl_y,
  output logic [9:0]                       snap_br_x,
  output logic [9:0]                       snap_br_y,
  output logic                             frame_done,
  output logic [19:0]                      pix_count
);

  localparam int         HW     = NUM_COLORS * HIST_DEPTH;
  localparam logic [9:0] X_LIM  = 10'(H_RES);
  localparam logic [9:0] Y_LIM  = 10'(V_RES);
  localparam logic [9:0] X_INIT = 10'(H_RES - 1);
  localparam logic [9:0] Y_INIT = 10'(V_RES - 1);

  logic                  vs_prev;
  logic [NUM_COLORS-1:0] wk_seen, sn_valid;
  logic [9:0] wk_xmax [NUM_COLORS];
  logic [9:0] wk_xmin [NUM_COLORS];
  logic [9:0] wk_ymax [NUM_COLORS];
  logic [9:0] wk_ymin [NUM_COLORS];
  logic [9:0] wk_tl_x [NUM_COLORS], wk_tl_y [NUM_COLORS];
  logic [9:0] wk_tr_x [NUM_COLORS], wk_tr_y [NUM_COLORS];
  logic [9:0] wk_bl_x [NUM_COLORS], wk_bl_y [NUM_COLORS];
  logic [9:0] wk_br_x [NUM_COLORS], wk_br_y [NUM_COLORS];
  logic [9:0] sn_tl_x [NUM_COLORS], sn_tl_y [NUM_COLORS];
  logic [9:0] sn_tr_x [NUM_COLORS], sn_tr_y [NUM_COLORS];
  logic [9:0] sn_bl_x [NUM_COLORS], sn_bl_y [NUM_COLORS];
  logic [9:0] sn_br_x [NUM_COLORS], sn_br_y [NUM_COLORS];

  logic [NUM_COLORS-1:0] raw_match, qual_match;
  logic [HW-1:0]         hist_next;
  logic                  win_found;
  logic [2:0]            win_idx;
  logic [2:0]            corner_next;
  logic                  boundary, in_range;

  function automatic logic [3:0] popcount(input logic [HIST_DEPTH-1:0] h);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < HIST_DEPTH; i++) n = n + {3'b000, h[i]};
    return n;
  endfunction

  assign boundary = vs_prev & ~vga_vs;
  assign in_range = (rd_x < X_LIM) && (rd_y < Y_LIM);

  // Classification, history shift and lowest-index winner selection. The
  // corner lookup is done against the winner's previous-frame snapshot.
  always_comb begin
    raw_match   = '0;
    qual_match  = '0;
    hist_next   = '0;
    win_found   = 1'b0;
    win_idx     = '0;
    corner_next = '0;
    for (int c = 0; c < NUM_COLORS; c++) begin
      raw_match[c] = (cb >= cb_lo[c*8 +: 8]) && (cb <= cb_hi[c*8 +: 8]) &&
                     (cr >= cr_lo[c*8 +: 8]) && (cr <= cr_hi[c*8 +: 8]);
      qual_match[c] = raw_match[c] &&
                      (popcount(hist_in[c*HIST_DEPTH +: HIST_DEPTH]) > hist_thresh[c*4 +: 4]);
      hist_next[c*HIST_DEPTH +: HIST_DEPTH] = {hist_in[c*HIST_DEPTH +: HIST_DEPTH-1], raw_match[c]};
      if (qual_match[c] && !win_found) begin
        win_found = 1'b1;
        win_idx   = 3'(c);
        if (sn_valid[c]) begin
          if (rd_x == sn_tl_x[c] && rd_y == sn_tl_y[c])      corner_next = 3'd1;
          else if (rd_x == sn_tr_x[c] && rd_y == sn_tr_y[c]) corner_next = 3'd2;
          else if (rd_x == sn_bl_x[c] && rd_y == sn_bl_y[c]) corner_next = 3'd3;
          else if (rd_x == sn_br_x[c] && rd_y == sn_br_y[c]) corner_next = 3'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev    <= 1'b0;
      det_valid  <= 1'b0;
      we         <= 1'b0;
      det_color  <= '0;
      det_corner <= '0;
      det_x      <= '0;
      det_y      <= '0;
      hist_out   <= '0;
      wr_addr    <= '0;
      frame_done <= 1'b0;
      wk_seen    <= '0;
      sn_valid   <= '0;
      for (int c = 0; c < NUM_COLORS; c++) begin
        wk_xmax[c] <= '0;     wk_xmin[c] <= X_INIT;
        wk_ymax[c] <= '0;     wk_ymin[c] <= Y_INIT;
        wk_tl_x[c] <= '0;     wk_tl_y[c] <= '0;
        wk_tr_x[c] <= '0;     wk_tr_y[c] <= '0;
        wk_bl_x[c] <= '0;     wk_bl_y[c] <= '0;
        wk_br_x[c] <= '0;     wk_br_y[c] <= '0;
        sn_tl_x[c] <= '0;     sn_tl_y[c] <= '0;
        sn_tr_x[c] <= '0;     sn_tr_y[c] <= '0;
        sn_bl_x[c] <= '0;     sn_bl_y[c] <= '0;
        sn_br_x[c] <= '0;     sn_br_y[c] <= '0;
      end
    end else begin
      vs_prev    <= vga_vs;
      frame_done <= boundary;
      det_valid  <= 1'b0;
      we         <= 1'b0;
      if (boundary) begin
        // The pixel on the boundary cycle is dropped; outputs hold.
        sn_valid <= wk_seen;
        wk_seen  <= '0;
        for (int c = 0; c < NUM_COLORS; c++) begin
          sn_tl_x[c] <= wk_tl_x[c];  sn_tl_y[c] <= wk_tl_y[c];
          sn_tr_x[c] <= wk_tr_x[c];  sn_tr_y[c] <= wk_tr_y[c];
          sn_bl_x[c] <= wk_bl_x[c];  sn_bl_y[c] <= wk_bl_y[c];
          sn_br_x[c] <= wk_br_x[c];  sn_br_y[c] <= wk_br_y[c];
          wk_xmax[c] <= '0;          wk_xmin[c] <= X_INIT;
          wk_ymax[c] <= '0;          wk_ymin[c] <= Y_INIT;
          wk_tl_x[c] <= '0;          wk_tl_y[c] <= '0;
          wk_tr_x[c] <= '0;          wk_tr_y[c] <= '0;
          wk_bl_x[c] <= '0;          wk_bl_y[c] <= '0;
          wk_br_x[c] <= '0;          wk_br_y[c] <= '0;
        end
      end else if (pix_valid) begin
        det_valid  <= 1'b1;
        we         <= 1'b1;
        wr_addr    <= rd_addr;
        det_x      <= rd_x;
        det_y      <= rd_y;
        hist_out   <= hist_next;
        det_color  <= win_found ? win_idx + 3'd1 : 3'd0;
        det_corner <= corner_next;
        // Cleared bounds (xmax=0, xmin=H_RES-1, ...) make the first in-range
        // pixel of a frame satisfy all four compares, setting every point.
        // Non-strict compares let later pixels win ties.
        if (win_found && in_range) begin
          for (int c = 0; c < NUM_COLORS; c++) begin
            if (win_idx == 3'(c)) begin
              wk_seen[c] <= 1'b1;
              if (rd_x >= wk_xmax[c]) begin
                wk_xmax[c] <= rd_x;  wk_br_x[c] <= rd_x;  wk_br_y[c] <= rd_y;
              end
              if (rd_x <= wk_xmin[c]) begin
                wk_xmin[c] <= rd_x;  wk_tl_x[c] <= rd_x;  wk_tl_y[c] <= rd_y;
              end
              if (rd_y >= wk_ymax[c]) begin
                wk_ymax[c] <= rd_y;  wk_bl_x[c] <= rd_x;  wk_bl_y[c] <= rd_y;
              end
              if (rd_y <= wk_ymin[c]) begin
                wk_ymin[c] <= rd_y;  wk_tr_x[c] <= rd_x;  wk_tr_y[c] <= rd_y;
              end
            end
          end
        end
      end
    end
  end

  // Snapshot read mux; an out-of-range select reads as all zeros.
  always_comb begin
    snap_valid = 1'b0;
    snap_tl_x = '0;  snap_tl_y = '0;
    snap_tr_x = '0;  snap_tr_y = '0;
    snap_bl_x = '0;  snap_bl_y = '0;
    snap_br_x = '0;  snap_br_y = '0;
    for (int c = 0; c < NUM_COLORS; c++) begin
      if (sel_color == 3'(c)) begin
        snap_valid = sn_valid[c];
        snap_tl_x = sn_tl_x[c];  snap_tl_y = sn_tl_y[c];
        snap_tr_x = sn_tr_x[c];  snap_tr_y = sn_tr_y[c];
        snap_bl_x = sn_bl_x[c];  snap_bl_y = sn_bl_y[c];
        snap_br_x = sn_br_x[c];  snap_br_y = sn_br_y[c];
      end
    end
  end

`ifdef CHROMA_PIXEL_COUNT_EN
  logic [19:0] wk_cnt [NUM_COLORS];
  logic [19:0] sn_cnt [NUM_COLORS];

  // Counts every winning pixel, in range or not, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_COLORS; c++) begin
        wk_cnt[c] <= '0;
        sn_cnt[c] <= '0;
      end
    end else if (boundary) begin
      for (int c = 0; c < NUM_COLORS; c++) begin
        sn_cnt[c] <= wk_cnt[c];
        wk_cnt[c] <= '0;
      end
    end else if (pix_valid && win_found) begin
      for (int c = 0; c < NUM_COLORS; c++) begin
        if (win_idx == 3'(c) && wk_cnt[c] != '1) wk_cnt[c] <= wk_cnt[c] + 20'd1;
      end
    end
  end

  always_comb begin
    pix_count = '0;
    for (int c = 0; c < NUM_COLORS; c++) begin
      if (sel_color == 3'(c)) pix_count = sn_cnt[c];
    end
  end
`else
  assign pix_count = '0;
`endif

endmodule

// File: tb/tb_chroma_multi_tracker.sv
// tb/tb_chroma_multi_tracker.sv - self-checking bench for chroma_multi_tracker

module tb_chroma_multi_tracker;

  localparam int NC = 2;
  localparam int HD = 4;
  localparam int HR = 640;
  localparam int VR = 480;
  localparam int AW = 19;

  logic clk = 1'b0;
  logic reset;
  logic vga_vs, pix_valid;
  logic [7:0] cb, cr;
  logic [9:0] rd_x, rd_y;
  logic [AW-1:0] rd_addr;
  logic [NC*HD-1:0] hist_in;
  logic [NC*8-1:0] cb_lo, cb_hi, cr_lo, cr_hi;
  logic [NC*4-1:0] hist_thresh;
  logic det_valid, we, snap_valid, frame_done;
  logic [2:0] det_color, det_corner, sel_color;
  logic [9:0] det_x, det_y;
  logic [NC*HD-1:0] hist_out;
  logic [AW-1:0] wr_addr;
  logic [9:0] snap_tl_x, snap_tl_y, snap_tr_x, snap_tr_y;
  logic [9:0] snap_bl_x, snap_bl_y, snap_br_x, snap_br_y;
  logic [19:0] pix_count;

  chroma_multi_tracker #(.NUM_COLORS(NC), .HIST_DEPTH(HD), .H_RES(HR), .V_RES(VR), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .vga_vs(vga_vs), .pix_valid(pix_valid),
    .cb(cb), .cr(cr), .rd_x(rd_x), .rd_y(rd_y), .rd_addr(rd_addr), .hist_in(hist_in),
    .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi), .hist_thresh(hist_thresh),
    .det_valid(det_valid), .det_color(det_color), .det_corner(det_corner),
    .det_x(det_x), .det_y(det_y), .hist_out(hist_out), .we(we), .wr_addr(wr_addr),
    .sel_color(sel_color), .snap_valid(snap_valid),
    .snap_tl_x(snap_tl_x), .snap_tl_y(snap_tl_y), .snap_tr_x(snap_tr_x), .snap_tr_y(snap_tr_y),
    .snap_bl_x(snap_bl_x), .snap_bl_y(snap_bl_y), .snap_br_x(snap_br_x), .snap_br_y(snap_br_y),
    .frame_done(frame_done), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is kept as the list of in-range winning pixels;
  // snapshot corners are derived from that list when the frame closes.
  typedef struct { int ch; int x; int y; } pt_t;
  typedef struct { bit sv; int tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y; int cnt; } snap_t;

  pt_t   wq[$];
  snap_t m_snap [NC];
  int    m_cnt [NC];
  bit    m_vs_prev;
  logic  e_valid, e_fd;
  logic [2:0] e_color, e_corner;
  logic [9:0] e_x, e_y;
  logic [NC*HD-1:0] e_hist;
  logic [AW-1:0] e_addr;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_snap[c] = '{default: 0};
      m_cnt[c] = 0;
    end
    wq.delete();
    m_vs_prev = 1'b0;
    e_valid = 1'b0; e_fd = 1'b0; e_color = '0; e_corner = '0;
    e_x = '0; e_y = '0; e_hist = '0; e_addr = '0;
  endtask

  task automatic take_snapshot();
    int mnx, mxx, mny, mxy;
    bit any;
    for (int c = 0; c < NC; c++) begin
      m_snap[c] = '{default: 0};
      any = 1'b0; mnx = 99999; mxx = -1; mny = 99999; mxy = -1;
      foreach (wq[i]) if (wq[i].ch == c) begin
        any = 1'b1;
        if (wq[i].x < mnx) mnx = wq[i].x;
        if (wq[i].x > mxx) mxx = wq[i].x;
        if (wq[i].y < mny) mny = wq[i].y;
        if (wq[i].y > mxy) mxy = wq[i].y;
      end
      if (any) begin
        m_snap[c].sv = 1'b1;
        // Scanning in arrival order leaves the last pixel reaching each extreme.
        foreach (wq[i]) if (wq[i].ch == c) begin
          if (wq[i].x == mnx) begin m_snap[c].tl_x = wq[i].x; m_snap[c].tl_y = wq[i].y; end
          if (wq[i].y == mny) begin m_snap[c].tr_x = wq[i].x; m_snap[c].tr_y = wq[i].y; end
          if (wq[i].y == mxy) begin m_snap[c].bl_x = wq[i].x; m_snap[c].bl_y = wq[i].y; end
          if (wq[i].x == mxx) begin m_snap[c].br_x = wq[i].x; m_snap[c].br_y = wq[i].y; end
        end
      end
      m_snap[c].cnt = m_cnt[c];
      m_cnt[c] = 0;
    end
    wq.delete();
  endtask

  task automatic model_step();
    int w;
    logic [HD-1:0] h;
    logic r;
    bit bnd;
    int px, py;
    bnd = m_vs_prev && !vga_vs;
    m_vs_prev = vga_vs;
    e_fd = bnd;
    e_valid = 1'b0;
    if (bnd) begin
      take_snapshot();
    end else if (pix_valid) begin
      e_valid = 1'b1; e_addr = rd_addr; e_x = rd_x; e_y = rd_y;
      w = -1;
      for (int c = 0; c < NC; c++) begin
        h = hist_in[c*HD +: HD];
        r = (cb >= cb_lo[c*8 +: 8]) && (cb <= cb_hi[c*8 +: 8]) &&
            (cr >= cr_lo[c*8 +: 8]) && (cr <= cr_hi[c*8 +: 8]);
        e_hist[c*HD +: HD] = {h[HD-2:0], r};
        if (w < 0 && r && $countones(h) > int'(hist_thresh[c*4 +: 4])) w = c;
      end
      e_color = '0; e_corner = '0;
      if (w >= 0) begin
        e_color = 3'(w + 1);
        px = int'(rd_x); py = int'(rd_y);
        if (m_snap[w].sv) begin
          if (px == m_snap[w].tl_x && py == m_snap[w].tl_y)      e_corner = 3'd1;
          else if (px == m_snap[w].tr_x && py == m_snap[w].tr_y) e_corner = 3'd2;
          else if (px == m_snap[w].bl_x && py == m_snap[w].bl_y) e_corner = 3'd3;
          else if (px == m_snap[w].br_x && py == m_snap[w].br_y) e_corner = 3'd4;
        end
        if (m_cnt[w] < 1048575) m_cnt[w]++;
        if (px < HR && py < VR) wq.push_back('{w, px, py});
      end
    end
  endtask

  task automatic compare_model();
    snap_t s;
    s = '{default: 0};
    if (int'(sel_color) < NC) s = m_snap[int'(sel_color)];
    chk("det_valid", 64'(det_valid), 64'(e_valid));
    chk("we", 64'(we), 64'(e_valid));
    chk("det_color", 64'(det_color), 64'(e_color));
    chk("det_corner", 64'(det_corner), 64'(e_corner));
    chk("det_x", 64'(det_x), 64'(e_x));
    chk("det_y", 64'(det_y), 64'(e_y));
    chk("hist_out", 64'(hist_out), 64'(e_hist));
    chk("wr_addr", 64'(wr_addr), 64'(e_addr));
    chk("frame_done", 64'(frame_done), 64'(e_fd));
    chk("snap_valid", 64'(snap_valid), 64'(s.sv));
    chk("snap_tl", 64'({snap_tl_x, snap_tl_y}), 64'({10'(s.tl_x), 10'(s.tl_y)}));
    chk("snap_tr", 64'({snap_tr_x, snap_tr_y}), 64'({10'(s.tr_x), 10'(s.tr_y)}));
    chk("snap_bl", 64'({snap_bl_x, snap_bl_y}), 64'({10'(s.bl_x), 10'(s.bl_y)}));
    chk("snap_br", 64'({snap_br_x, snap_br_y}), 64'({10'(s.br_x), 10'(s.br_y)}));
`ifdef CHROMA_PIXEL_COUNT_EN
    chk("pix_count", 64'(pix_count), 64'(s.cnt));
`else
    chk("pix_count", 64'(pix_count), 64'd0);
`endif
  endtask

  // Inputs are set before the call; the model advances, then the DUT is
  // sampled 1 time unit after the active edge.
  task automatic cycle();
    if (reset) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic set_px(input logic vs, input logic pv, input logic [7:0] c8,
                        input logic [9:0] x, input logic [9:0] y, input logic [7:0] h);
    vga_vs = vs; pix_valid = pv; cb = c8; cr = c8; rd_x = x; rd_y = y; hist_in = h;
  endtask

  typedef struct {
    logic vs, pv; logic [7:0] c8; logic [9:0] x, y; logic [7:0] h;
    logic ev; logic [2:0] ecol, ecor; logic [7:0] eh; logic efd;
  } vec_t;
  vec_t tbl [15];

  task automatic run_vec(input int i);
    set_px(tbl[i].vs, tbl[i].pv, tbl[i].c8, tbl[i].x, tbl[i].y, tbl[i].h);
    rd_addr = 19'(i * 7 + 3);
    cycle();
    chk($sformatf("tbl%0d_valid", i), 64'(det_valid), 64'(tbl[i].ev));
    chk($sformatf("tbl%0d_we", i), 64'(we), 64'(tbl[i].ev));
    chk($sformatf("tbl%0d_color", i), 64'(det_color), 64'(tbl[i].ecol));
    chk($sformatf("tbl%0d_corner", i), 64'(det_corner), 64'(tbl[i].ecor));
    chk($sformatf("tbl%0d_hist", i), 64'(hist_out), 64'(tbl[i].eh));
    chk($sformatf("tbl%0d_fd", i), 64'(frame_done), 64'(tbl[i].efd));
    if (tbl[i].ev) chk($sformatf("tbl%0d_addr", i), 64'(wr_addr), 64'(19'(i * 7 + 3)));
  endtask

  task automatic chk_snap(input string n, input logic [2:0] sel, input logic v,
                          input logic [9:0] tlx, input logic [9:0] tly, input logic [9:0] trx, input logic [9:0] try_y,
                          input logic [9:0] blx, input logic [9:0] bly, input logic [9:0] brx, input logic [9:0] bry);
    sel_color = sel;
    #1;
    chk({n, "_valid"}, 64'(snap_valid), 64'(v));
    chk({n, "_tl"}, 64'({snap_tl_x, snap_tl_y}), 64'({tlx, tly}));
    chk({n, "_tr"}, 64'({snap_tr_x, snap_tr_y}), 64'({trx, try_y}));
    chk({n, "_bl"}, 64'({snap_bl_x, snap_bl_y}), 64'({blx, bly}));
    chk({n, "_br"}, 64'({snap_br_x, snap_br_y}), 64'({brx, bry}));
    sel_color = 3'd0;
  endtask

  int vs_low;

  initial begin
    // ch0 window 90..110, ch1 window 95..120, both thresholds 2.
    //         vs    pv    cb/cr   x        y        hist    ev    col   cor   hist_out fd
    tbl[0]  = '{1'b1, 1'b1, 8'd100, 10'd10,  10'd50,  8'h0F, 1'b1, 3'd1, 3'd0, 8'h1F, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'd100, 10'd11,  10'd60,  8'h01, 1'b1, 3'd0, 3'd0, 8'h13, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'd100, 10'd200, 10'd5,   8'hFF, 1'b1, 3'd1, 3'd0, 8'hFF, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'd100, 10'd630, 10'd100, 8'h77, 1'b1, 3'd1, 3'd0, 8'hFF, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'd100, 10'd300, 10'd470, 8'h77, 1'b1, 3'd1, 3'd0, 8'hFF, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'd100, 10'd700, 10'd10,  8'h0F, 1'b1, 3'd1, 3'd0, 8'h1F, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'd115, 10'd320, 10'd240, 8'hFF, 1'b1, 3'd2, 3'd0, 8'hFE, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'd100, 10'd1,   10'd1,   8'hFF, 1'b0, 3'd2, 3'd0, 8'hFE, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'd100, 10'd200, 10'd5,   8'hFF, 1'b0, 3'd2, 3'd0, 8'hFE, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'd100, 10'd1,   10'd1,   8'h00, 1'b0, 3'd2, 3'd0, 8'hFE, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'd100, 10'd200, 10'd5,   8'h0F, 1'b1, 3'd1, 3'd2, 8'h1F, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'd115, 10'd320, 10'd240, 8'hF0, 1'b1, 3'd2, 3'd1, 8'hF0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'd100, 10'd10,  10'd50,  8'h0F, 1'b1, 3'd1, 3'd1, 8'h1F, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 8'd100, 10'd630, 10'd100, 8'h0F, 1'b1, 3'd1, 3'd4, 8'h1F, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 8'd100, 10'd300, 10'd470, 8'h0F, 1'b1, 3'd1, 3'd3, 8'h1F, 1'b0};

    reset = 1'b1; sel_color = 3'd0; rd_addr = '0;
    cb_lo = {8'd95, 8'd90}; cb_hi = {8'd120, 8'd110};
    cr_lo = {8'd95, 8'd90}; cr_hi = {8'd120, 8'd110};
    hist_thresh = {4'd2, 4'd2};
    set_px(1'b1, 1'b0, 8'd0, 10'd0, 10'd0, 8'h00);
    cycle();
    cycle();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i);
    chk_snap("snap_c0", 3'd0, 1'b1, 10'd10, 10'd50, 10'd200, 10'd5, 10'd300, 10'd470, 10'd630, 10'd100);
    chk_snap("snap_c1", 3'd1, 1'b1, 10'd320, 10'd240, 10'd320, 10'd240, 10'd320, 10'd240, 10'd320, 10'd240);
    chk_snap("snap_sel2", 3'd2, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
    for (int i = 10; i < 15; i++) run_vec(i);

    // Close the frame, then a frame whose only winner lies outside the active area.
    set_px(1'b0, 1'b0, 8'd0, 10'd0, 10'd0, 8'h00); cycle();
    chk("fd_after_vs", 64'(frame_done), 64'd1);
    set_px(1'b1, 1'b1, 8'd100, 10'd700, 10'd10, 8'h0F); rd_addr = 19'd4242; cycle();
    chk("x700_we", 64'(we), 64'd1);
    chk("x700_hist", 64'(hist_out), 64'h1F);
    chk("x700_addr", 64'(wr_addr), 64'd4242);
    set_px(1'b0, 1'b0, 8'd0, 10'd0, 10'd0, 8'h00); cycle();
    chk_snap("empty_c0", 3'd0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
    set_px(1'b1, 1'b0, 8'd0, 10'd0, 10'd0, 8'h00); cycle();
    chk("fd_one_cycle", 64'(frame_done), 64'd0);

`ifdef CHROMA_PIXEL_COUNT_EN
    for (int i = 0; i < 1000; i++) begin
      set_px(1'b1, 1'b1, 8'd100, 10'(i % 640), 10'(i / 640), 8'h0F);
      cycle();
    end
    set_px(1'b0, 1'b0, 8'd0, 10'd0, 10'd0, 8'h00); cycle();
    chk("pix_count_1000", 64'(pix_count), 64'd1000);
`endif

    // Reset in the middle of a frame: no snapshot, and a low vs straight
    // after reset is not a boundary.
    set_px(1'b1, 1'b1, 8'd100, 10'd50, 10'd60, 8'h0F); cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    set_px(1'b0, 1'b0, 8'd0, 10'd0, 10'd0, 8'h00); cycle();
    chk("rst_no_fd", 64'(frame_done), 64'd0);
    chk("rst_snap_valid", 64'(snap_valid), 64'd0);
    chk("rst_pix_count", 64'(pix_count), 64'd0);
    set_px(1'b1, 1'b0, 8'd0, 10'd0, 10'd0, 8'h00); cycle();
    chk("rst_no_fd2", 64'(frame_done), 64'd0);

    // Randomized traffic against the model.
    vs_low = 0;
    for (int n = 0; n < 3000; n++) begin
      if (vs_low > 0) begin
        vga_vs = 1'b0;
        vs_low--;
      end else begin
        vga_vs = 1'b1;
        if ($urandom_range(0, 79) == 0) begin
          vs_low = $urandom_range(1, 3);
          for (int c = 0; c < NC; c++) begin
            cb_lo[c*8 +: 8] = 8'($urandom_range(80, 100));
            cb_hi[c*8 +: 8] = 8'($urandom_range(100, 125));
            cr_lo[c*8 +: 8] = 8'($urandom_range(80, 100));
            cr_hi[c*8 +: 8] = 8'($urandom_range(100, 125));
            hist_thresh[c*4 +: 4] = 4'($urandom_range(0, 4));
          end
        end
      end
      pix_valid = ($urandom_range(0, 9) < 8);
      cb = 8'($urandom_range(78, 127));
      cr = 8'($urandom_range(78, 127));
      rd_x = 10'($urandom_range(0, 15) * 45);
      rd_y = 10'($urandom_range(0, 11) * 45);
      rd_addr = 19'($urandom);
      hist_in = 8'($urandom);
      sel_color = 3'($urandom_range(0, 3));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
